// File: rtl/fetch_stage_pkg.sv
// Shared constants and enums for the instruction-fetch stage.
package fetch_stage_pkg;
   localparam int          XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {FETCH, HOLD, KILL} fetch_state_e;
   typedef enum logic [1:0] {PC_KEEP, PC_SEQ, PC_BRANCH, PC_REDIR} pc_sel_e;
endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Next-PC mux: keep, sequential (+4), EX redirect, or the deferred redirect.
module pc_next_sel
   import fetch_stage_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] redir,
   input  pc_sel_e         sel,
   output logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] pc_next
);
   assign pc_plus4 = pc + XLEN'(4);

   always_comb begin
      pc_next = pc;
      unique case (sel)
         PC_SEQ:    pc_next = pc_plus4;
         PC_BRANCH: pc_next = branch_target;
         PC_REDIR:  pc_next = redir;
         default:   pc_next = pc;
      endcase
   end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM, IF/ID register.
//  state | meaning
//  FETCH | request outstanding at pc_q; response consumed or buffered
//  HOLD  | response buffered in hold_q while decode is stalled, no request
//  KILL  | redirect arrived before response; wait it out, then jump to redir_q
module fetch_stage
   import fetch_stage_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc_plus4,
   output logic [31:0]     if_id_instr,
   output logic            if_id_valid
);
   fetch_state_e    state_q, state_d;
   pc_sel_e         pc_sel;
   logic [XLEN-1:0] pc_q, pc_next, pc_plus4;
   logic [XLEN-1:0] redir_q, redir_d;
   logic [31:0]     hold_q, hold_d;
   logic [31:0]     ifid_instr_d;
   logic            ifid_load, ifid_bubble;

   pc_next_sel u_pc_next_sel (
      .pc            (pc_q),
      .branch_target (branch_target),
      .redir         (redir_q),
      .sel           (pc_sel),
      .pc_plus4      (pc_plus4),
      .pc_next       (pc_next)
   );

   assign imem_req  = !reset && (state_q != HOLD);
   assign imem_addr = pc_q;

   always_comb begin
      state_d      = state_q;
      pc_sel       = PC_KEEP;
      redir_d      = redir_q;
      hold_d       = hold_q;
      ifid_load    = 1'b0;
      ifid_bubble  = 1'b0;
      ifid_instr_d = imem_rdata;
      unique case (state_q)
         FETCH: begin
            if (branch_taken) begin
               ifid_bubble = 1'b1;
               if (imem_valid) begin
                  pc_sel = PC_BRANCH;
               end else begin
                  redir_d = branch_target;
                  state_d = KILL;
               end
            end else if (imem_valid) begin
               if (!stall) begin
                  ifid_load = 1'b1;
                  pc_sel    = PC_SEQ;
               end else begin
                  hold_d  = imem_rdata;
                  state_d = HOLD;
               end
            end else if (!stall) begin
               ifid_bubble = 1'b1;
            end
         end
         HOLD: begin
            ifid_instr_d = hold_q;
            if (branch_taken) begin
               ifid_bubble = 1'b1;
               hold_d      = '0;
               pc_sel      = PC_BRANCH;
               state_d     = FETCH;
            end else if (!stall) begin
               ifid_load = 1'b1;
               pc_sel    = PC_SEQ;
               state_d   = FETCH;
            end
         end
         KILL: begin
            // pc_q stays on the old address until the stale response drains
            if (branch_taken) begin
               ifid_bubble = 1'b1;
               redir_d     = branch_target;
            end else if (!stall) begin
               ifid_bubble = 1'b1;
            end
            if (imem_valid) begin
               if (branch_taken) pc_sel = PC_BRANCH;
               else              pc_sel = PC_REDIR;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= FETCH;
         pc_q           <= RESET_PC;
         redir_q        <= '0;
         hold_q         <= '0;
         if_id_valid    <= 1'b0;
         if_id_instr    <= NOP_INSTR;
         if_id_pc       <= '0;
         if_id_pc_plus4 <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_next;
         redir_q <= redir_d;
         hold_q  <= hold_d;
         if (ifid_load) begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= ifid_instr_d;
            if_id_pc       <= pc_q;
            if_id_pc_plus4 <= pc_plus4;
         end else if (ifid_bubble) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
         end
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level model, directed scenarios, then randomized traffic.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int M_WANT = 0, M_BUF = 1, M_DOOM = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1, stall = 1'b0, branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_valid = 1'b0;
   logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
   logic        if_id_valid;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_valid     (imem_valid),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_instr    (if_id_instr),
      .if_id_valid    (if_id_valid)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;

   // Model: which address is wanted, whether a fetched word waits for decode,
   // or whether the in-flight response is doomed; plus the expected IF/ID contents.
   int          m_mode;
   logic [31:0] m_pc, m_redir;
   logic        e_valid;
   logic [31:0] e_instr, e_pc, e_pc4;

   int          lat_left, lat_cfg;
   bit          force_valid;
   logic        last_req;
   logic [31:0] last_addr;

   function automatic logic [31:0] tag(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic int new_lat();
      if (lat_cfg < 0) return int'($urandom_range(0, 3));
      return lat_cfg;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_WANT; m_pc = 32'h0; m_redir = '0;
      e_valid = 1'b0; e_instr = NOP; e_pc = '0; e_pc4 = '0;
   endtask

   task automatic deliver();
      e_valid = 1'b1; e_instr = tag(m_pc); e_pc = m_pc; e_pc4 = m_pc + 32'd4;
      m_pc = m_pc + 32'd4; m_mode = M_WANT;
   endtask

   task automatic bubble();
      e_valid = 1'b0; e_instr = NOP;
   endtask

   task automatic model_step(input bit r, input bit s, input bit b, input logic [31:0] t, input bit v);
      if (r) model_reset();
      else if (m_mode == M_WANT) begin
         if (b) begin
            bubble();
            if (v) m_pc = t;
            else begin m_redir = t; m_mode = M_DOOM; end
         end else if (v && !s) deliver();
         else if (v) m_mode = M_BUF;
         else if (!s) bubble();
      end else if (m_mode == M_BUF) begin
         if (b) begin bubble(); m_pc = t; m_mode = M_WANT; end
         else if (!s) deliver();
      end else begin
         if (b) begin bubble(); m_redir = t; end
         else if (!s) bubble();
         if (v) begin m_pc = b ? t : m_redir; m_mode = M_WANT; end
      end
   endtask

   // One clock: drive inputs, check request side, answer memory, check IF/ID after the edge.
   task automatic cycle(input bit r, input bit s, input bit b, input logic [31:0] t);
      bit exp_req, v;
      reset = r; stall = s; branch_taken = b; branch_target = t;
      #1;
      exp_req   = !r && (m_mode != M_BUF);
      last_req  = imem_req;
      last_addr = imem_addr;
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      v = (exp_req && lat_left == 0) || force_valid;
      imem_valid = v;
      imem_rdata = v ? tag(imem_addr) : 32'hDEAD_BEEF;
      @(posedge clk);
      model_step(r, s, b, t, v);
      if (r || v) lat_left = new_lat();
      else if (exp_req && lat_left > 0) lat_left--;
      @(negedge clk);
      chk("if_id_valid", 32'(if_id_valid), 32'(e_valid));
      chk("if_id_instr", if_id_instr, e_instr);
      chk("if_id_pc", if_id_pc, e_pc);
      chk("if_id_pc_plus4", if_id_pc_plus4, e_pc4);
   endtask

   initial begin
      bit r, s, b;
      logic [31:0] t;
      model_reset();
      lat_cfg = 0; lat_left = 0; force_valid = 0;
      @(negedge clk);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      chk("rst_valid", 32'(if_id_valid), 32'd0);
      chk("rst_instr", if_id_instr, NOP);

      // zero-wait streaming
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 0);
         chk("t1_pc", if_id_pc, 32'(4 * i));
         chk("t1_pc4", if_id_pc_plus4, 32'(4 * i + 4));
      end

      // three-cycle memory latency
      lat_cfg = 3; lat_left = 3;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 0);
         chk("t2_addr_held", last_addr, 32'h10);
         chk("t2_bubble", if_id_instr, NOP);
      end
      cycle(0, 0, 0, 0);
      chk("t2_pc", if_id_pc, 32'h10);

      // stall on response -> buffered, no request while held
      lat_cfg = 0; lat_left = 0;
      cycle(0, 1, 0, 0);
      chk("t3_hold_pc", if_id_pc, 32'h10);
      cycle(0, 1, 0, 0);
      chk("t3_req_off", 32'(last_req), 32'd0);
      chk("t3_hold_pc2", if_id_pc, 32'h10);
      cycle(0, 0, 0, 0);
      chk("t3_release", if_id_pc, 32'h14);
      chk("t3_instr", if_id_instr, 32'h14 ^ 32'hC0DE_0000);

      // redirect while the request for 0x18 is outstanding
      lat_left = 2;
      cycle(0, 0, 1, 32'h100);
      chk("t4_flush", 32'(if_id_valid), 32'd0);
      cycle(0, 0, 0, 0);
      chk("t4_addr_old", last_addr, 32'h18);
      cycle(0, 0, 0, 0);
      chk("t4_no_killed", 32'(if_id_valid), 32'd0);
      cycle(0, 0, 0, 0);
      chk("t4_new_addr", last_addr, 32'h100);
      chk("t4_pc", if_id_pc, 32'h100);

      // flush beats stall
      cycle(0, 1, 1, 32'h40);
      chk("t5_valid", 32'(if_id_valid), 32'd0);
      chk("t5_nop", if_id_instr, NOP);
      cycle(0, 0, 0, 0);
      chk("t5_addr", last_addr, 32'h40);

      // PC wrap
      cycle(0, 0, 1, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 0);
      chk("t6_pc", if_id_pc, 32'hFFFF_FFFC);
      chk("t6_pc4_wrap", if_id_pc_plus4, 32'h0);
      cycle(0, 0, 0, 0);
      chk("t6_addr_wrap", last_addr, 32'h0);

      // reset during a pending request, with a stray response in the reset cycle
      lat_left = 3;
      cycle(0, 0, 0, 0);
      force_valid = 1;
      cycle(1, 0, 0, 0);
      force_valid = 0;
      chk("t6_rst_valid", 32'(if_id_valid), 32'd0);
      chk("t6_rst_pc", if_id_pc, 32'h0);
      cycle(0, 0, 0, 0);
      chk("t6_after_rst", if_id_pc, 32'h0);

      // randomized traffic
      lat_cfg = -1;
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 99) == 0);
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
         else if ($urandom_range(0, 7) == 0) t = $urandom;
         else t = $urandom & 32'h0000_FFFC;
         cycle(r, s, b, t);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
